// File: rtl/blink_sequencer.sv
// LED blink sequencer: emits `count` on/off pulses whose on and off phases last
// on_len and off_len ticks, where one tick is CLK_DIV clock cycles.
module blink_sequencer #(
  parameter int unsigned CLK_DIV = 25000000,
  parameter int unsigned W       = 8
) (
  input  logic         clk,
  input  logic         aclr,
  input  logic         start,
  input  logic         stop,
  input  logic [W-1:0] on_len,
  input  logic [W-1:0] off_len,
  input  logic [W-1:0] count,
  output logic         led,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] remaining
);

  localparam int unsigned   PW      = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PresMax = PW'(CLK_DIV - 1);
  localparam logic [W-1:0]  One     = W'(1);

  typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  phase_q, phase_d;
  logic [W-1:0]  on_len_q, on_len_d;
  logic [W-1:0]  off_len_q, off_len_d;
  logic [W-1:0]  remaining_q, remaining_d;
  logic          led_q, led_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tick;

  // The prescaler only advances while busy, so a tick is never seen in idle.
  assign tick = busy_q && (presc_q == PresMax);

  // Next-state logic: operand capture, phase timing and abort handling.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    phase_d     = phase_q;
    on_len_d    = on_len_q;
    off_len_d   = off_len_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        presc_d = '0;
        phase_d = '0;
        if (start) begin
          // Zero lengths behave as one tick so a phase can never stall.
          on_len_d    = (on_len == '0) ? One : on_len;
          off_len_d   = (off_len == '0) ? One : off_len;
          remaining_d = count;
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StOn;
          end
        end
      end

      StOn, StOff: begin
        if (stop) begin
          // Abort takes priority over any tick on the same edge.
          state_d     = StIdle;
          presc_d     = '0;
          phase_d     = '0;
          remaining_d = '0;
        end else begin
          // Prescaler runs free across ON/OFF boundaries.
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            if (state_q == StOn && phase_q == on_len_q - One) begin
              state_d = StOff;
              phase_d = '0;
            end else if (state_q == StOff && phase_q == off_len_q - One) begin
              phase_d = '0;
              if (remaining_q > One) begin
                remaining_d = remaining_q - One;
                state_d     = StOn;
              end else begin
                remaining_d = '0;
                state_d     = StIdle;
                done_d      = 1'b1;
              end
            end else begin
              phase_d = phase_q + One;
            end
          end
        end
      end

      default: state_d = StIdle;
    endcase

    led_d  = (state_d == StOn);
    busy_d = (state_d != StIdle);
  end

  // State and registered outputs; reset clears everything including captured operands.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      phase_q     <= '0;
      on_len_q    <= '0;
      off_len_q   <= '0;
      remaining_q <= '0;
      led_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      phase_q     <= phase_d;
      on_len_q    <= on_len_d;
      off_len_q   <= off_len_d;
      remaining_q <= remaining_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign led       = led_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Directed bench for blink_sequencer with CLK_DIV=4, W=8.
module tb_blink_sequencer;

  logic       clk;
  logic       aclr;
  logic       start;
  logic       stop;
  logic [7:0] on_len;
  logic [7:0] off_len;
  logic [7:0] count;
  logic       led;
  logic       busy;
  logic       done;
  logic [7:0] remaining;

  int n_chk;
  int n_err;
  int led_log  [64];
  int busy_log [64];
  int done_log [64];
  int rem_log  [64];
  int led_n;
  int busy_n;
  int done_n;

  blink_sequencer #(
    .CLK_DIV(4),
    .W      (8)
  ) dut (
    .clk      (clk),
    .aclr     (aclr),
    .start    (start),
    .stop     (stop),
    .on_len   (on_len),
    .off_len  (off_len),
    .count    (count),
    .led      (led),
    .busy     (busy),
    .done     (done),
    .remaining(remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; accept edge is the next posedge, returns at the negedge after it.
  task automatic pulse_start(input int on_v, input int off_v, input int cnt_v);
    on_len  = 8'(on_v);
    off_len = 8'(off_v);
    count   = 8'(cnt_v);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Logs n negedge samples (index 0 = current negedge); optionally raises start/stop
  // for one cycle at a given index.
  task automatic observe(input int n, input int start_at, input int stop_at);
    led_n  = 0;
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < n; i++) begin
      led_log[i]  = int'(led);
      busy_log[i] = int'(busy);
      done_log[i] = int'(done);
      rem_log[i]  = int'(remaining);
      led_n  += int'(led);
      busy_n += int'(busy);
      done_n += int'(done);
      start = (i == start_at);
      stop  = (i == stop_at);
      @(negedge clk);
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    aclr    = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    on_len  = '0;
    off_len = '0;
    count   = '0;
    repeat (3) @(negedge clk);
    check("rst_led", int'(led), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rem", int'(remaining), 0);
    aclr = 1'b1;
    @(negedge clk);

    // Stop in idle does nothing.
    observe(4, -1, 0);
    check("idle_stop_busy", busy_n, 0);
    check("idle_stop_done", done_n, 0);

    // on=2 off=1 count=2: led 8 on, 4 off, 8 on, 4 off.
    pulse_start(2, 1, 2);
    observe(30, -1, -1);
    check("a_busy_cycles", busy_n, 24);
    check("a_led_cycles", led_n, 16);
    check("a_done_cycles", done_n, 1);
    check("a_led7", led_log[7], 1);
    check("a_led8", led_log[8], 0);
    check("a_led12", led_log[12], 1);
    check("a_led20", led_log[20], 0);
    check("a_rem0", rem_log[0], 2);
    check("a_rem12", rem_log[12], 1);
    check("a_rem24", rem_log[24], 0);
    check("a_busy23", busy_log[23], 1);
    check("a_busy24", busy_log[24], 0);
    check("a_done24", done_log[24], 1);

    // count=0: immediate done, never busy.
    pulse_start(3, 3, 0);
    observe(5, -1, -1);
    check("z_done0", done_log[0], 1);
    check("z_done_cycles", done_n, 1);
    check("z_busy_cycles", busy_n, 0);
    check("z_led_cycles", led_n, 0);

    // Zero lengths act as one tick.
    pulse_start(0, 0, 1);
    observe(12, -1, -1);
    check("l_led_cycles", led_n, 4);
    check("l_busy_cycles", busy_n, 8);
    check("l_led3", led_log[3], 1);
    check("l_led4", led_log[4], 0);
    check("l_done8", done_log[8], 1);

    // Stop (with start also high) 5 cycles into ON aborts without done.
    pulse_start(3, 1, 3);
    observe(12, 5, 5);
    check("s_busy5", busy_log[5], 1);
    check("s_rem5", rem_log[5], 3);
    check("s_led6", led_log[6], 0);
    check("s_busy6", busy_log[6], 0);
    check("s_rem6", rem_log[6], 0);
    check("s_busy_cycles", busy_n, 6);
    check("s_done_cycles", done_n, 0);

    // Start during OFF with new operands is ignored.
    pulse_start(2, 2, 2);
    on_len  = 8'd5;
    off_len = 8'd5;
    count   = 8'd7;
    observe(40, 10, -1);
    check("i_busy_cycles", busy_n, 32);
    check("i_led_cycles", led_n, 16);
    check("i_rem16", rem_log[16], 1);
    check("i_led16", led_log[16], 1);
    check("i_done32", done_log[32], 1);
    check("i_done_cycles", done_n, 1);

    // Restart while done is high, with stop also high in idle.
    pulse_start(1, 1, 1);
    observe(8, -1, -1);
    check("r_done_hi", int'(done), 1);
    on_len  = 8'd2;
    off_len = 8'd1;
    count   = 8'd1;
    start   = 1'b1;
    stop    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("r_busy", int'(busy), 1);
    check("r_led", int'(led), 1);
    check("r_rem", int'(remaining), 1);
    check("r_done_lo", int'(done), 0);
    observe(14, -1, -1);
    check("r_busy_cycles", busy_n, 12);
    check("r_done12", done_log[12], 1);

    // Asynchronous reset mid-OFF.
    pulse_start(1, 2, 2);
    observe(7, -1, -1);
    check("x_busy6", busy_log[6], 1);
    check("x_led6", led_log[6], 0);
    check("x_rem6", rem_log[6], 2);
    aclr = 1'b0;
    #1;
    check("x_async_busy", int'(busy), 0);
    check("x_async_led", int'(led), 0);
    check("x_async_rem", int'(remaining), 0);
    check("x_async_done", int'(done), 0);
    @(negedge clk);
    aclr = 1'b1;
    @(negedge clk);
    observe(4, -1, -1);
    check("x_idle_busy", busy_n, 0);
    check("x_idle_done", done_n, 0);
    pulse_start(1, 1, 1);
    observe(10, -1, -1);
    check("x_new_busy_cycles", busy_n, 8);
    check("x_new_led_cycles", led_n, 4);
    check("x_new_done8", done_log[8], 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
